// File: rtl/alsu_seg_display.sv
// ALSU output stage: captures a result, converts it to sign + two BCD digits and scans it onto a
// 4-digit common-anode display. Define ALSU_SEG_BLINK_EN to blink the "Err" message.
module alsu_seg_display #(
    parameter int CLK_DIV    = 50000,
    parameter int BLINK_DIV  = 25000000,
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds,
    input  logic        load,
    output logic        busy,
    output logic        err,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp
);
    localparam logic [3:0] SYM_DASH  = 4'd10;
    localparam logic [3:0] SYM_E     = 4'd11;
    localparam logic [3:0] SYM_R     = 4'd12;
    localparam logic [3:0] SYM_BLANK = 4'd15;
    localparam int SCAN_W = $clog2(CLK_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state;
    logic [2:0]       step;
    logic [3:0][3:0]  dig;
    logic             accept;
    logic [5:0]       bin_p0;
    logic [7:0]       bcd_p0;
    logic             neg_p0;
    logic             inv_p0;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]       idx;
    logic             blink_off;

    function automatic logic [6:0] seg_enc(input logic [3:0] sym);
        case (sym)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'd10:   return 7'b0111111;
            4'd11:   return 7'b0000110;
            4'd12:   return 7'b0101111;
            default: return 7'b1111111;
        endcase
    endfunction

    // -32 negates to 6'b100000, which read unsigned is the required 32
    function automatic logic [5:0] magnitude(input logic signed [5:0] v);
        if (SIGNED_OUT && (v < 0))
            return 6'(-v);
        return 6'(v);
    endfunction

    function automatic logic [7:0] dabble_step(input logic [7:0] bcd, input logic b);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
        ones = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        return 8'({tens, ones, b});
    endfunction

    assign accept = (state == IDLE) && load && !busy;
    assign dp     = 1'b1;

    // stage p0: capture and iterative binary-to-BCD shift
    always_ff @(posedge clk) begin
        if (accept) begin
            bin_p0 <= magnitude(signed'(alsu_out));
            neg_p0 <= SIGNED_OUT && alsu_out[5];
            inv_p0 <= |alsu_leds;
            bcd_p0 <= '0;
        end else if (state == CONV) begin
            bin_p0 <= {bin_p0[4:0], 1'b0};
            bcd_p0 <= dabble_step(bcd_p0, bin_p0[5]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            step  <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
            dig   <= {4{SYM_BLANK}};
        end else begin
            busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= CONV;
                        step  <= '0;
                    end
                end
                CONV: begin
                    if (step == 3'd5)
                        state <= DONE;
                    else
                        step <= step + 3'd1;
                end
                DONE: begin
                    state <= IDLE;
                    err   <= inv_p0;
                    if (inv_p0)
                        dig <= {SYM_E, SYM_R, SYM_R, SYM_BLANK};
                    else
                        dig <= {neg_p0 ? SYM_DASH : SYM_BLANK, SYM_BLANK,
                                (bcd_p0[7:4] == 4'd0) ? SYM_BLANK : bcd_p0[7:4],
                                bcd_p0[3:0]};
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALSU_SEG_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (!err) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    assign blink_off = 1'b0;
`endif

    // stage p1: digit scan, anode and cathode registered together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            anode    <= 4'b1111;
            cathode  <= 7'h7F;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            anode   <= blink_off ? 4'b1111 : ~(4'b0001 << idx);
            cathode <= seg_enc(dig[idx]);
        end
    end
endmodule

// File: tb/tb_alsu_seg_display.sv
// Bench for alsu_seg_display: signed and unsigned instances driven together and compared every
// cycle against a digit-level model; directed literal checks pin the model.
module tb_alsu_seg_display;
    localparam int CD = 4;
    localparam int BD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  alsu_out = '0;
    logic [15:0] alsu_leds = '0;
    logic        load = 1'b0;

    logic       busy_s, err_s, dp_s, busy_u, err_u, dp_u;
    logic [3:0] an_s, an_u;
    logic [6:0] ca_s, ca_u;

    int total = 0;
    int passed = 0;
    bit cmp_en = 1'b0;

    alsu_seg_display #(.CLK_DIV(CD), .BLINK_DIV(BD), .SIGNED_OUT(1'b1)) u_s (
        .clk(clk), .rst(rst), .alsu_out(alsu_out), .alsu_leds(alsu_leds), .load(load),
        .busy(busy_s), .err(err_s), .anode(an_s), .cathode(ca_s), .dp(dp_s));

    alsu_seg_display #(.CLK_DIV(CD), .BLINK_DIV(BD), .SIGNED_OUT(1'b0)) u_u (
        .clk(clk), .rst(rst), .alsu_out(alsu_out), .alsu_leds(alsu_leds), .load(load),
        .busy(busy_u), .err(err_u), .anode(an_u), .cathode(ca_u), .dp(dp_u));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000;  10: return 7'b0111111; 11: return 7'b0000110;
            12: return 7'b0101111; default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0][6:0] render(input logic [5:0] v, input logic [15:0] l,
                                               input bit sgn);
        int mag;
        bit neg;
        if (l != 16'h0) return {glyph(11), glyph(12), glyph(12), glyph(15)};
        neg = sgn && v[5];
        mag = neg ? 64 - int'(v) : int'(v);
        return {neg ? glyph(10) : glyph(15), glyph(15),
                (mag / 10 != 0) ? glyph(mag / 10) : glyph(15), glyph(mag % 10)};
    endfunction

    // Model: ph counts edges since an accepted load (1 after the capture edge)
    int ph, e, m, idx;
    bit off;
    logic [5:0]  cap_v;
    logic [15:0] cap_l;
    logic [3:0][6:0] disp_s, disp_u;
    logic err_m, exp_busy;
    logic [3:0] exp_an;
    logic [6:0] exp_ca_s, exp_ca_u;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph = 0; e = 0; m = 0; err_m = 1'b0; exp_busy = 1'b0;
            disp_s = {4{7'h7F}}; disp_u = {4{7'h7F}};
            exp_an = 4'hF; exp_ca_s = 7'h7F; exp_ca_u = 7'h7F;
        end else begin
            idx = (e / CD) % 4;
`ifdef ALSU_SEG_BLINK_EN
            off = ((m / BD) % 2) == 1;
`else
            off = 1'b0;
`endif
            exp_an = off ? 4'hF : ~(4'b0001 << idx);
            exp_ca_s = disp_s[idx];
            exp_ca_u = disp_u[idx];
            if (err_m) m++; else m = 0;
            e++;
            if (ph == 0) begin
                if (load) begin
                    ph = 1; cap_v = alsu_out; cap_l = alsu_leds;
                end
            end else begin
                ph++;
                if (ph == 8) begin
                    disp_s = render(cap_v, cap_l, 1'b1);
                    disp_u = render(cap_v, cap_l, 1'b0);
                    err_m = (cap_l != 16'h0);
                end
                if (ph == 9) ph = 0;
            end
            exp_busy = (ph >= 2) && (ph <= 8);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy_s", 16'(busy_s), 16'(exp_busy));
            chk("busy_u", 16'(busy_u), 16'(exp_busy));
            chk("err_s", 16'(err_s), 16'(err_m));
            chk("err_u", 16'(err_u), 16'(err_m));
            chk("anode_s", 16'(an_s), 16'(exp_an));
            chk("anode_u", 16'(an_u), 16'(exp_an));
            chk("cathode_s", 16'(ca_s), 16'(exp_ca_s));
            chk("cathode_u", 16'(ca_u), 16'(exp_ca_u));
            chk("dp_s", 16'(dp_s), 16'h1);
            chk("dp_u", 16'(dp_u), 16'h1);
        end
    end

    task automatic do_load(input logic [5:0] v, input logic [15:0] l);
        @(negedge clk);
        alsu_out = v; alsu_leds = l; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_an(input string nm, input bit uns, input logic [3:0] pat,
                           input logic [6:0] exp);
        int n;
        logic [3:0] a;
        n = 0;
        do begin
            @(negedge clk);
            a = uns ? an_u : an_s;
            n++;
        end while (a != pat && n < 40);
        if (a != pat) chk({nm, "_timeout"}, 16'(a), 16'(pat));
        else chk(nm, 16'(uns ? ca_u : ca_s), 16'(exp));
    endtask

    task automatic reset_check(input string nm);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk({nm, "_anode"}, 16'(an_s), 16'hF);
        chk({nm, "_cathode"}, 16'(ca_s), 16'h7F);
        chk({nm, "_dp"}, 16'(dp_s), 16'h1);
        chk({nm, "_busy"}, 16'(busy_s), 16'h0);
        chk({nm, "_err"}, 16'(err_s), 16'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int nb;
        #3 rst = 1'b0;
        #1;
        chk("rst0_anode", 16'(an_s), 16'hF);
        chk("rst0_cathode", 16'(ca_s), 16'h7F);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cmp_en = 1'b1;
        repeat (5) @(negedge clk);

        // 12 -> " 12", busy exactly 7 cycles
        do_load(6'd12, 16'h0);
        nb = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy_s) nb++;
        end
        chk("busy_len", 16'(nb), 16'd7);
        wait_an("d12_d0", 1'b0, 4'b1110, 7'b0100100);
        wait_an("d12_d1", 1'b0, 4'b1101, 7'b1111001);
        wait_an("d12_d2", 1'b0, 4'b1011, 7'b1111111);
        wait_an("d12_d3", 1'b0, 4'b0111, 7'b1111111);

        do_load(6'b111011, 16'h0);
        repeat (10) @(negedge clk);
        wait_an("m5_d3", 1'b0, 4'b0111, 7'b0111111);
        wait_an("m5_d1", 1'b0, 4'b1101, 7'b1111111);
        wait_an("m5_d0", 1'b0, 4'b1110, 7'b0010010);

        do_load(6'b100000, 16'h0);
        repeat (10) @(negedge clk);
        wait_an("m32_d3", 1'b0, 4'b0111, 7'b0111111);
        wait_an("m32_d1", 1'b0, 4'b1101, 7'b0110000);
        wait_an("m32_d0", 1'b0, 4'b1110, 7'b0100100);

        do_load(6'd63, 16'h0);
        repeat (10) @(negedge clk);
        wait_an("u63_d3", 1'b1, 4'b0111, 7'b1111111);
        wait_an("u63_d1", 1'b1, 4'b1101, 7'b0000010);
        wait_an("u63_d0", 1'b1, 4'b1110, 7'b0110000);

        do_load(6'd5, 16'h0001);
        repeat (10) @(negedge clk);
        chk("err_set", 16'(err_s), 16'h1);
        wait_an("err_d3", 1'b0, 4'b0111, 7'b0000110);
        wait_an("err_d2", 1'b0, 4'b1011, 7'b0101111);
        wait_an("err_d0", 1'b0, 4'b1110, 7'b1111111);
        repeat (40) @(negedge clk);

        // second load during conversion is dropped
        do_load(6'd7, 16'h0);
        repeat (2) @(negedge clk);
        do_load(6'd9, 16'h0);
        repeat (12) @(negedge clk);
        wait_an("drop_d0", 1'b0, 4'b1110, 7'b1111000);
        wait_an("drop_d1", 1'b0, 4'b1101, 7'b1111111);

        do_load(6'd25, 16'h0);
        reset_check("rst_conv");
        repeat (12) @(negedge clk);
        wait_an("rst_conv_blank", 1'b0, 4'b1110, 7'b1111111);

        for (int it = 0; it < 250; it++) begin
            int gap, hold;
            gap = $urandom_range(0, 12);
            hold = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 2);
            @(negedge clk);
            alsu_out = 6'($urandom);
            alsu_leds = ($urandom_range(0, 3) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'h0;
            load = 1'b1;
            repeat (hold) @(negedge clk);
            load = 1'b0;
            repeat (gap) @(negedge clk);
            if ($urandom_range(0, 40) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end

        reset_check("rst_run");
        repeat (10) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
